// File: rtl/gecko_decode_scoreboard_pkg.sv
// Shared scoreboard types: register status encoding,
// operand readiness bundle and counter sizing helpers.
package gecko_decode_scoreboard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    REG_VALID   = 2'd0,
    REG_PARTIAL = 2'd1,
    REG_FULL    = 2'd2
  } gecko_reg_status_t;

  typedef struct packed {
    logic rs1_ok;
    logic rs2_ok;
    logic rd_ok;
  } operand_status_t;

  function automatic int max_count(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int dec_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic gecko_reg_status_t status_of(
    input int unsigned cnt,
    input int unsigned max
  );
    if (cnt == 0)
      return REG_VALID;
    else if (cnt == max)
      return REG_FULL;
    else
      return REG_PARTIAL;
  endfunction

endpackage

// File: rtl/gecko_scoreboard_counter.sv
// One register's outstanding-write counter: saturating
// up/down with a flagged underflow and a clear.
import gecko_decode_scoreboard_pkg::*;

module gecko_scoreboard_counter #(
  parameter int W  = 2,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [DW-1:0] dec_count,
  input  logic          clear,
  output logic [W-1:0]  count,
  output logic          underflow
);

  localparam int SW = ((W > DW) ? W : DW) + 2;
  localparam logic [W-1:0] MAX = W'(max_count(W));

  logic [SW-1:0] up;
  logic [SW-1:0] dn;
  logic [W-1:0]  nxt;

  // net issue/retire update, saturating at both ends
  always_comb begin
    up        = SW'(count) + SW'(inc);
    dn        = SW'(dec_count);
    underflow = !clear && (dn > up);
    nxt       = count;
    if (clear)
      nxt = '0;
    else if (dn > up)
      nxt = '0;
    else if ((up - dn) > SW'(MAX))
      nxt = MAX;
    else
      nxt = W'(up - dn);
  end

  // counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else
      count <= nxt;
  end

endmodule

// File: rtl/gecko_decode_scoreboard.sv
// Decode-stage register scoreboard with per-register write counters.
// Optional execute reuse bypass: GECKO_SCOREBOARD_BYPASS_EN.
import gecko_decode_scoreboard_pkg::*;

module gecko_decode_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int COUNTER_WIDTH   = 2,
  parameter int NUM_WB_CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [4:0]                issue_rs1,
  input  logic [4:0]                issue_rs2,
  input  logic [4:0]                issue_rd,
  input  logic                      issue_rs1_used,
  input  logic                      issue_rs2_used,
  input  logic                      issue_rd_used,
  input  logic [4:0]                execute_saved_reg,
  output logic                      rs1_ok,
  output logic                      rs2_ok,
  output logic                      rd_ok,
  input  logic [NUM_WB_CHANNELS-1:0] wb_valid,
  input  logic [NUM_WB_CHANNELS-1:0][4:0] wb_addr,
  input  logic                      flush,
  output logic [NUM_REGS-1:0][1:0]  reg_status,
  output logic                      underflow_error
);

  localparam int CW = COUNTER_WIDTH;
  localparam int DW = dec_width(NUM_WB_CHANNELS);
  localparam logic [CW-1:0] MAX = CW'(max_count(CW));

  logic [CW-1:0]   cnt [32];
  logic [31:0]     uf;
  operand_status_t ok;
  logic            accept;

  assign accept = issue_valid && issue_ready;

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (i > 0 && i < NUM_REGS) begin : g_cnt
      logic          inc_i;
      logic [DW-1:0] dec_i;

      assign inc_i = accept && issue_rd_used &&
                     (issue_rd == 5'(i));

      // count retire channels targeting this register
      always_comb begin
        dec_i = '0;
        for (int c = 0; c < NUM_WB_CHANNELS; c++)
          if (wb_valid[c] && wb_addr[c] == 5'(i))
            dec_i = dec_i + 1'b1;
      end

      gecko_scoreboard_counter #(
        .W  (CW),
        .DW (DW)
      ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_i),
        .dec_count (dec_i),
        .clear     (flush),
        .count     (cnt[i]),
        .underflow (uf[i])
      );
    end else begin : g_zero
      assign cnt[i] = '0;
      assign uf[i]  = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_status
    assign reg_status[i] = status_of(32'(cnt[i]), 32'(MAX));
  end

`ifndef GECKO_SCOREBOARD_BYPASS_EN
  logic unused_saved;
  assign unused_saved = ^execute_saved_reg;
`endif

  // operand readiness from registered counters only
  always_comb begin
    ok.rs1_ok = !issue_rs1_used || issue_rs1 == '0 ||
                cnt[issue_rs1] == '0;
    ok.rs2_ok = !issue_rs2_used || issue_rs2 == '0 ||
                cnt[issue_rs2] == '0;
    ok.rd_ok  = !issue_rd_used || issue_rd == '0 ||
                cnt[issue_rd] != MAX;
`ifdef GECKO_SCOREBOARD_BYPASS_EN
    if (issue_rs1 == execute_saved_reg &&
        issue_rs1 != '0 && cnt[issue_rs1] == CW'(1))
      ok.rs1_ok = 1'b1;
    if (issue_rs2 == execute_saved_reg &&
        issue_rs2 != '0 && cnt[issue_rs2] == CW'(1))
      ok.rs2_ok = 1'b1;
`endif
  end

  assign rs1_ok      = ok.rs1_ok;
  assign rs2_ok      = ok.rs2_ok;
  assign rd_ok       = ok.rd_ok;
  assign issue_ready = ok.rs1_ok && ok.rs2_ok && ok.rd_ok;

  // sticky underflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst)
      underflow_error <= 1'b0;
    else if (|uf)
      underflow_error <= 1'b1;
  end

endmodule

// File: tb/tb_gecko_decode_scoreboard.sv
// Directed vector bench for the decode scoreboard.
// Table of per-cycle vectors plus reset and bypass sequences.
module tb_gecko_decode_scoreboard;

  localparam int ST_V = 0;
  localparam int ST_P = 1;
  localparam int ST_F = 2;

`ifdef GECKO_SCOREBOARD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic [4:0]      issue_rd;
  logic            issue_rs1_used;
  logic            issue_rs2_used;
  logic            issue_rd_used;
  logic [4:0]      execute_saved_reg;
  logic            rs1_ok;
  logic            rs2_ok;
  logic            rd_ok;
  logic [1:0]      wb_valid;
  logic [1:0][4:0] wb_addr;
  logic            flush;
  logic [31:0][1:0] reg_status;
  logic            underflow_error;

  int checks = 0;
  int errors = 0;

  gecko_decode_scoreboard dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_rs1         (issue_rs1),
    .issue_rs2         (issue_rs2),
    .issue_rd          (issue_rd),
    .issue_rs1_used    (issue_rs1_used),
    .issue_rs2_used    (issue_rs2_used),
    .issue_rd_used     (issue_rd_used),
    .execute_saved_reg (execute_saved_reg),
    .rs1_ok            (rs1_ok),
    .rs2_ok            (rs2_ok),
    .rd_ok             (rd_ok),
    .wb_valid          (wb_valid),
    .wb_addr           (wb_addr),
    .flush             (flush),
    .reg_status        (reg_status),
    .underflow_error   (underflow_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst; int iv;
    int rs1; int u1; int rs2; int u2; int rd; int ud;
    int wv; int wa0; int wa1; int fl;
    int rdy; int ok1; int ok2; int okd;
    int creg; int cst; int uf;
  } vec_t;

  vec_t vec [$];

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst               = 1'b1;
    issue_valid       = 1'b0;
    issue_rs1         = '0;
    issue_rs2         = '0;
    issue_rd          = '0;
    issue_rs1_used    = 1'b0;
    issue_rs2_used    = 1'b0;
    issue_rd_used     = 1'b0;
    execute_saved_reg = '0;
    wb_valid          = '0;
    wb_addr           = '0;
    flush             = 1'b0;
  endtask

  task automatic issue_rd_once(input int rd);
    @(negedge clk);
    idle_inputs();
    issue_valid   = 1'b1;
    issue_rd      = 5'(rd);
    issue_rd_used = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    // rst, iv, rs1,u1, rs2,u2, rd,ud, wv,wa0,wa1, fl,
    // rdy,ok1,ok2,okd, creg,cst,uf
    vec.push_back('{1,1, 0,0, 0,0, 5,1, 0,0,0, 0, 1,1,1,1, 5,ST_P,0});
    vec.push_back('{1,1, 5,1, 2,1, 10,1, 0,0,0, 0, 0,0,1,1, 10,ST_V,0});
    vec.push_back('{1,0, 5,1, 0,0, 0,0, 1,5,0, 0, 0,0,1,1, 5,ST_V,0});
    vec.push_back('{1,1, 0,0, 0,0, 7,1, 0,0,0, 0, 1,1,1,1, 7,ST_P,0});
    vec.push_back('{1,1, 0,0, 0,0, 7,1, 0,0,0, 0, 1,1,1,1, 7,ST_P,0});
    vec.push_back('{1,1, 0,0, 0,0, 7,1, 0,0,0, 0, 1,1,1,1, 7,ST_F,0});
    vec.push_back('{1,1, 0,0, 0,0, 7,1, 0,0,0, 0, 0,1,1,0, 7,ST_F,0});
    vec.push_back('{1,1, 0,0, 0,0, 7,1, 2,0,7, 0, 0,1,1,0, 7,ST_P,0});
    vec.push_back('{1,1, 0,0, 0,0, 7,1, 0,0,0, 0, 1,1,1,1, 7,ST_F,0});
    vec.push_back('{1,1, 0,0, 0,0, 3,1, 0,0,0, 0, 1,1,1,1, 3,ST_P,0});
    vec.push_back('{1,1, 0,0, 0,0, 3,1, 1,3,0, 0, 1,1,1,1, 3,ST_P,0});
    vec.push_back('{1,1, 0,0, 0,0, 3,1, 0,0,0, 0, 1,1,1,1, 3,ST_P,0});
    vec.push_back('{1,0, 0,0, 0,0, 0,0, 3,3,3, 0, 1,1,1,1, 3,ST_V,0});
    vec.push_back('{1,0, 0,0, 0,0, 0,0, 1,9,0, 0, 1,1,1,1, 9,ST_V,1});
    vec.push_back('{1,0, 0,0, 0,0, 0,0, 0,0,0, 0, 1,1,1,1, 9,ST_V,1});
    vec.push_back('{1,1, 0,0, 0,0, 4,1, 0,0,0, 0, 1,1,1,1, 4,ST_P,1});
    vec.push_back('{1,1, 0,0, 0,0, 4,1, 0,0,0, 0, 1,1,1,1, 4,ST_P,1});
    vec.push_back('{1,1, 0,0, 0,0, 6,1, 0,0,0, 0, 1,1,1,1, 6,ST_P,1});
    vec.push_back('{1,1, 0,0, 0,0, 4,1, 1,7,0, 1, 1,1,1,1, 4,ST_V,1});
    vec.push_back('{1,0, 0,0, 0,0, 0,0, 0,0,0, 0, 1,1,1,1, 6,ST_V,1});
    vec.push_back('{1,0, 0,0, 0,0, 0,0, 0,0,0, 0, 1,1,1,1, 7,ST_V,1});
    vec.push_back('{0,1, 0,0, 0,0, 12,1, 0,0,0, 0, 1,1,1,1, 12,ST_V,0});
    vec.push_back('{1,1, 0,1, 0,0, 0,1, 1,0,0, 0, 1,1,1,1, 0,ST_V,0});
    vec.push_back('{1,1, 0,0, 0,0, 2,1, 0,0,0, 0, 1,1,1,1, 2,ST_P,0});
    vec.push_back('{1,1, 2,1, 0,0, 0,0, 0,0,0, 1, 0,0,1,1, 2,ST_V,0});

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", int'(issue_ready), 1);
    chk("reset underflow", int'(underflow_error), 0);
    for (int r = 0; r < 32; r++)
      chk($sformatf("reset status r%0d", r),
          int'(reg_status[r]), ST_V);

    foreach (vec[k]) begin
      @(negedge clk);
      rst               = 1'(vec[k].rst);
      issue_valid       = 1'(vec[k].iv);
      issue_rs1         = 5'(vec[k].rs1);
      issue_rs1_used    = 1'(vec[k].u1);
      issue_rs2         = 5'(vec[k].rs2);
      issue_rs2_used    = 1'(vec[k].u2);
      issue_rd          = 5'(vec[k].rd);
      issue_rd_used     = 1'(vec[k].ud);
      wb_valid          = 2'(vec[k].wv);
      wb_addr[0]        = 5'(vec[k].wa0);
      wb_addr[1]        = 5'(vec[k].wa1);
      flush             = 1'(vec[k].fl);
      execute_saved_reg = '0;
      #1;
      chk($sformatf("v%0d ready", k),
          int'(issue_ready), vec[k].rdy);
      chk($sformatf("v%0d rs1_ok", k),
          int'(rs1_ok), vec[k].ok1);
      chk($sformatf("v%0d rs2_ok", k),
          int'(rs2_ok), vec[k].ok2);
      chk($sformatf("v%0d rd_ok", k),
          int'(rd_ok), vec[k].okd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d status r%0d", k, vec[k].creg),
          int'(reg_status[vec[k].creg]), vec[k].cst);
      chk($sformatf("v%0d underflow", k),
          int'(underflow_error), vec[k].uf);
    end

    issue_rd_once(8);
    chk("byp setup r8", int'(reg_status[8]), ST_P);
    issue_rs1         = 5'd8;
    issue_rs1_used    = 1'b1;
    execute_saved_reg = 5'd8;
    #1;
    chk("byp rs1_ok cnt1", int'(rs1_ok), BYP);
    chk("byp ready cnt1", int'(issue_ready), BYP);
    issue_rs2         = 5'd8;
    issue_rs2_used    = 1'b1;
    #1;
    chk("byp rs2_ok cnt1", int'(rs2_ok), BYP);
    execute_saved_reg = 5'd9;
    #1;
    chk("byp rs1_ok other", int'(rs1_ok), 0);

    issue_rd_once(8);
    issue_rs1         = 5'd8;
    issue_rs1_used    = 1'b1;
    execute_saved_reg = 5'd8;
    #1;
    chk("byp rs1_ok cnt2", int'(rs1_ok), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gecko_decode_scoreboard.md
GECKO_DECODE_SCOREBOARD -- requirements
Module: gecko_decode_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count; index 0 is x0.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 2, per-register outstanding-write counter width; MAX = 2^COUNTER_WIDTH-1.
REQ-003 SHALL have parameter NUM_WB_CHANNELS, default 2, independent writeback-retire channels.
REQ-004 SHALL have ports, clock and reset first; ports are 1 bit unless a width is given:
- clk  in  1  clock, all state on rising edge;
- rst  in  1  synchronous active-low reset;
- issue_valid  in  1  decode presents an instruction;
- issue_ready  out  1  scoreboard accepts it;
- issue_rs1, issue_rs2, issue_rd  in  5 each  register addresses;
- issue_rs1_used, issue_rs2_used, issue_rd_used  in  1 each  the operand is actually used;
- execute_saved_reg  in  5  register currently held for reuse by execute;
- rs1_ok, rs2_ok, rd_ok  out  1 each  per-operand status, same encoding as decode operand status;
- wb_valid  in  NUM_WB_CHANNELS  retire strobes;
- wb_addr  in  NUM_WB_CHANNELS x 5  retired register addresses;
- flush  in  1  discard all in-flight writes;
- reg_status  out  NUM_REGS x 2  per-register gecko_reg_status_t;
- underflow_error  out  1  sticky: a retire was seen with the counter at 0.

Function
REQ-005 rs_ok SHALL be 1 when the operand is unused, the address is 0, the counter is 0, or (REQ-019) a bypass match exists.
REQ-006 rd_ok SHALL be 1 when rd is unused, rd is 0, or counter[rd] != MAX.
REQ-007 issue_ready SHALL be rs1_ok & rs2_ok & rd_ok, computed combinationally from registered counters only; a same-cycle retire does not raise ready.
REQ-008 An issue is accepted on issue_valid & issue_ready; on acceptance with rd used and rd != 0, counter[rd] SHALL increment at the next edge.
REQ-009 Each wb_valid[c] with wb_addr[c] != 0 SHALL decrement counter[wb_addr[c]] by 1 at the next edge; k channels on one address decrement by k.
REQ-010 An issue and k retires on the same register in one cycle SHALL net to +1-k, applied in a single update.
REQ-011 A decrement below 0 SHALL saturate at 0 and set underflow_error until reset.
REQ-012 Register 0 counter SHALL stay 0; retires and issues to x0 are ignored.
REQ-013 flush SHALL zero all counters at the next edge, take priority over issue and retire in that cycle, and leave underflow_error unchanged; issue_ready is unaffected in the flush cycle.
REQ-014 reg_status[i] SHALL be VALID when the counter is 0, FULL when it equals MAX, and PARTIAL otherwise.
REQ-015 Issue acceptance is zero-latency; counter effects are visible on all outputs exactly 1 cycle later.

Reset
REQ-016 With rst=0 at an edge, all counters SHALL become 0 and underflow_error 0; reset overrides flush, issue and retire.
REQ-017 During and after reset, reg_status SHALL be all VALID and issue_ready SHALL follow REQ-007 (1 for a hazard-free instruction).

Configuration
REQ-018 Macro GECKO_SCOREBOARD_BYPASS_EN SHALL gate the execute reuse bypass.
REQ-019 With the macro defined, rs1_ok/rs2_ok SHALL also be 1 when the address equals execute_saved_reg, the address is != 0, and counter == 1.
REQ-020 Without the macro, execute_saved_reg SHALL be ignored and readiness SHALL depend on counter == 0 only.

Structure
REQ-021 gecko_reg_status_t, the status encoding and MAX-derivation helpers SHALL live in the shared gecko package; the operand-status struct SHALL be reused from the decode utility package.
REQ-022 A sub-module gecko_scoreboard_counter SHALL hold one saturating up/down counter (inc, dec_count, clear, underflow output), instantiated NUM_REGS-1 times.

Verification
REQ-023 Reset, then issue rd=5 -> next cycle reg_status[5]=PARTIAL; ADD with rs1=5 gives rs1_ok=0 and issue_ready=0.
REQ-024 Three issues to rd=7 (COUNTER_WIDTH=2) -> status FULL; a fourth with rd=7 gives rd_ok=0; one retire of 7 -> next cycle rd_ok=1.
REQ-025 Issue rd=3 and retire 3 in the same cycle with counter=1 -> counter stays 1; two channels retiring 3 with counter=2 -> 0, VALID.
REQ-026 Retire 9 with counter 0 -> counter stays 0, underflow_error=1 and held; flush does not clear it, rst=0 does.
REQ-027 Counters at 4=2 and 6=1, then flush plus an issue to rd=4 -> all counters VALID next cycle.
REQ-028 With the bypass macro, counter[8]=1 and execute_saved_reg=8 -> rs1_ok=1; same case without the macro -> rs1_ok=0; issue_rd=0 and retire of 0 -> reg_status[0] stays VALID.
